// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: instruction width,
// HALT opcode, fetch state encoding and a HALT decode helper.
package fetch_unit_pkg;

  // Instruction word width delivered to the decoder.
  localparam int DATA_WIDTH = 16;

  // Opcode field value (bits [15:12]) that stops fetch when halting is enabled.
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } fetch_state_e;

  // True when the instruction word carries the HALT opcode.
  function automatic logic is_halt(input logic [DATA_WIDTH-1:0] word);
    return word[15:12] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {instruction, pc} pairs for the decoder.
// Head is read combinationally; output is forced to zero while empty so the
// decoder-facing fields sit at zero after reset or a flush.
module fetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] entry_arr [DEPTH];

  // One storage register per slot; written only when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;

    // Capture pushed data into this slot.
    always_ff @(posedge clk) begin
      if (rst) begin
        entry_reg <= '0;
      end else if (push && !flush && (wr_ptr_reg == PW'(gi))) begin
        entry_reg <= din;
      end
    end

    assign entry_arr[gi] = entry_reg;
  end

  // Pointer and occupancy bookkeeping; flush discards everything, including a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign dout  = (count_reg != '0) ? entry_arr[rd_ptr_reg] : '0;
  assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory under a credit limit of DEPTH, buffers in-order responses in
// fetch_fifo and discards stale responses after a redirect.
// Optional feature macro: FETCH_HALT_EN (stop fetching after a HALT word).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  halted
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = DATA_WIDTH + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] rsp_pc_reg;
  logic [CW-1:0]         inflight_reg;
  logic [CW-1:0]         inflight_next;
  logic [CW-1:0]         drop_reg;
  logic [CW-1:0]         drop_next;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credit_used;
  logic [FW-1:0]         fifo_dout;
  logic                  pop;
  logic                  accept;
  logic                  rsp_keep;
  logic                  halt_hit;

  // A pop releases its slot in the same cycle, which is what sustains
  // one instruction per cycle with only two entries.
  assign pop         = instr_valid && instr_ready;
  assign credit_used = (CW+1)'(inflight_reg) + (CW+1)'(fifo_count) - (CW+1)'(pop);

  assign imem_req_valid = !rst && !redirect_valid && !halted && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_reg;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response arriving during a redirect is stale by definition.
  assign rsp_keep      = imem_rsp_valid && (drop_reg == '0) && !redirect_valid;
  assign inflight_next = inflight_reg + CW'(accept) - CW'(imem_rsp_valid);

`ifdef FETCH_HALT_EN
  fetch_state_e state_reg;
  fetch_state_e state_next;

  assign halt_hit = rsp_keep && is_halt(imem_rsp_data);
  assign halted   = (state_reg == ST_HALTED);

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_RUN;
    else     state_reg <= state_next;
  end

  // Enter HALTED on a kept HALT word; only a redirect resumes fetching.
  always_comb begin
    state_next = state_reg;
    if (redirect_valid)  state_next = ST_RUN;
    else if (halt_hit)   state_next = ST_HALTED;
  end
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // Number of upcoming responses to throw away after a redirect or HALT.
  always_comb begin
    drop_next = drop_reg;
    if (redirect_valid || halt_hit) begin
      drop_next = inflight_next;
    end else if (imem_rsp_valid && (drop_reg != '0)) begin
      drop_next = drop_reg - CW'(1);
    end
  end

  // PC, response-address and credit counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      rsp_pc_reg   <= RESET_PC;
      inflight_reg <= '0;
      drop_reg     <= '0;
    end else begin
      if (redirect_valid)  pc_reg <= redirect_pc;
      else if (accept)     pc_reg <= pc_reg + ADDR_WIDTH'(1);

      if (redirect_valid)  rsp_pc_reg <= redirect_pc;
      else if (rsp_keep)   rsp_pc_reg <= rsp_pc_reg + ADDR_WIDTH'(1);

      inflight_reg <= inflight_next;
      drop_reg     <= drop_next;
    end
  end

  fetch_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .din   ({imem_rsp_data, rsp_pc_reg}),
    .pop   (pop),
    .flush (redirect_valid),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign instr_valid = (fifo_count != '0);
  assign instruction = fifo_dout[FW-1:ADDR_WIDTH];
  assign instr_pc    = fifo_dout[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by
// randomized memory latency, back-pressure, redirects and resets, checked
// against a program-order stream model of expected fetch addresses.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int              AW    = 8;
  localparam int              DEPTH = 2;
  localparam logic [AW-1:0]   RPC   = 8'h00;

  logic                  clk;
  logic                  rst;
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [AW-1:0]         imem_req_addr;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instruction;
  logic [AW-1:0]         instr_pc;
  logic                  redirect_valid;
  logic [AW-1:0]         redirect_pc;
  logic                  halted;

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RESET_PC   (RPC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: accepted requests awaiting their in-order response.
  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } req_t;

  req_t mem_q[$];
  int   cyc       = 0;
  int   last_due  = 0;
  int   lat_min   = 1;
  int   lat_max   = 1;
  int   halt_addr = -1;

  // Stream model: next address the decoder should see and next address requested.
  logic [AW-1:0] exp_pc;
  logic [AW-1:0] exp_req;
  bit            halt_seen;
  int            n_deliv;
  int            n_acc;

  logic                  s_req_valid;
  logic [AW-1:0]         s_req_addr;
  logic                  s_ivalid;
  logic [DATA_WIDTH-1:0] s_instr;
  logic [AW-1:0]         s_ipc;
  logic                  s_halted;

  function automatic logic [DATA_WIDTH-1:0] memword(input logic [AW-1:0] a);
    if (int'(a) == halt_addr) return 16'hF000;
    return 16'h1000 + {8'h00, a};
  endfunction

  // One clock cycle: drive inputs, sample outputs mid-cycle, update the model.
  task automatic cycle(input logic ir, input logic mr, input logic rv,
                       input logic [AW-1:0] rpc, input logic rs);
    req_t r;
    int   lat;
    rst            = rs;
    instr_ready    = ir;
    imem_req_ready = mr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rs) begin
      mem_q.delete();
      last_due = 0;
    end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memword(mem_q[0].addr);
      void'(mem_q.pop_front());
    end

    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_ivalid    = instr_valid;
    s_instr     = instruction;
    s_ipc       = instr_pc;
    s_halted    = halted;

    if (rs) begin
      check_eq("req_in_reset", s_req_valid, 0);
      exp_pc    = RPC;
      exp_req   = RPC;
      halt_seen = 0;
    end else begin
      if (rv) check_eq("req_during_redirect", s_req_valid, 0);
      if (s_halted) check_eq("req_while_halted", s_req_valid, 0);
      if (halt_seen) check_eq("valid_after_halt", s_ivalid, 0);
`ifndef FETCH_HALT_EN
      check_eq("halted_tied_low", s_halted, 0);
`endif
      if (s_req_valid && mr) begin
        check_eq("req_addr", s_req_addr, exp_req);
        exp_req = exp_req + 1'b1;
        n_acc++;
        lat = $urandom_range(lat_max, lat_min);
        r.addr = s_req_addr;
        r.due  = cyc + lat;
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        mem_q.push_back(r);
      end
      if (s_ivalid && ir) begin
        check_eq("instr_pc", s_ipc, exp_pc);
        check_eq("instruction", s_instr, memword(exp_pc));
`ifdef FETCH_HALT_EN
        if (s_instr[15:12] == OP_HALT) halt_seen = 1;
`endif
        exp_pc = exp_pc + 1'b1;
        n_deliv++;
      end
      if (rv) begin
        exp_pc    = rpc;
        exp_req   = rpc;
        halt_seen = 0;
      end
      check_eq("outstanding_le_depth", (mem_q.size() <= DEPTH), 1);
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_two_inflight(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (mem_q.size() == 2) break;
      cycle(1, 1, 0, '0, 0);
    end
    check_eq(tag, mem_q.size(), 2);
  endtask

  initial begin
    rst            = 1'b1;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exp_pc         = RPC;
    exp_req        = RPC;
    halt_seen      = 0;
    n_deliv        = 0;
    n_acc          = 0;
    @(posedge clk);
    #1;

    // Reset state.
    repeat (3) cycle(1, 1, 0, '0, 1);
    check_eq("rst_instr_valid", s_ivalid, 0);
    check_eq("rst_instruction", s_instr, 0);
    check_eq("rst_instr_pc", s_ipc, 0);
    check_eq("rst_halted", s_halted, 0);

    // First fetches with 1-cycle memory: request in cycle 0, valid in cycle 2.
    lat_min = 1; lat_max = 1;
    cycle(1, 1, 0, '0, 0);
    check_eq("c0_req_valid", s_req_valid, 1);
    check_eq("c0_req_addr", s_req_addr, RPC);
    check_eq("c0_instr_valid", s_ivalid, 0);
    cycle(1, 1, 0, '0, 0);
    check_eq("c1_instr_valid", s_ivalid, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, '0, 0);
      check_eq("stream_valid", s_ivalid, 1);
      check_eq("stream_instr", s_instr, 16'h1000 + i);
      check_eq("stream_pc", s_ipc, i);
    end

    // Decoder stall: FIFO fills with addr 0/1, requests stop, then drain in order.
    repeat (2) cycle(1, 1, 0, '0, 1);
    n_acc = 0;
    repeat (5) cycle(0, 1, 0, '0, 0);
    check_eq("stall_req_count", n_acc, 2);
    check_eq("stall_req_valid", s_req_valid, 0);
    check_eq("stall_head_valid", s_ivalid, 1);
    check_eq("stall_head_pc", s_ipc, 0);
    n_deliv = 0;
    repeat (3) cycle(1, 1, 0, '0, 0);
    check_eq("stall_release_count", n_deliv, 3);

    // Redirect to 8'hFF with 1-cycle memory: next cycle requests FF, then wraps to 00.
    cycle(1, 1, 1, 8'hFF, 0);
    cycle(1, 1, 0, '0, 0);
    check_eq("redir_next_req_valid", s_req_valid, 1);
    check_eq("redir_next_req_addr", s_req_addr, 8'hFF);
    cycle(1, 1, 0, '0, 0);
    check_eq("wrap_req_addr", s_req_addr, 8'h00);
    n_deliv = 0;
    repeat (4) cycle(1, 1, 0, '0, 0);
    check_eq("wrap_deliveries", (n_deliv >= 2), 1);

    // Redirect to 8'h40 with two requests in flight on slow memory.
    lat_min = 3; lat_max = 3;
    repeat (2) cycle(1, 1, 0, '0, 1);
    wait_two_inflight("two_inflight_redirect");
    cycle(1, 1, 1, 8'h40, 0);
    n_deliv = 0;
    repeat (12) cycle(1, 1, 0, '0, 0);
    check_eq("after_redirect_deliveries", (n_deliv >= 2), 1);

    // Reset mid-stream with two in flight.
    repeat (2) cycle(1, 1, 0, '0, 1);
    wait_two_inflight("two_inflight_reset");
    repeat (2) cycle(1, 1, 0, '0, 1);
    check_eq("midrst_instr_valid", s_ivalid, 0);
    check_eq("midrst_instruction", s_instr, 0);
    check_eq("midrst_instr_pc", s_ipc, 0);
    check_eq("midrst_halted", s_halted, 0);
    cycle(1, 1, 0, '0, 0);
    check_eq("midrst_first_req", s_req_addr, RPC);
    n_deliv = 0;
    repeat (8) cycle(1, 1, 0, '0, 0);
    check_eq("midrst_deliveries", (n_deliv >= 1), 1);

`ifdef FETCH_HALT_EN
    // HALT word at address 3: delivered, then fetch stops until a redirect.
    lat_min = 1; lat_max = 1;
    halt_addr = 3;
    repeat (2) cycle(1, 1, 0, '0, 1);
    n_deliv = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 0, '0, 0);
      if (s_halted) break;
    end
    check_eq("halt_asserted", s_halted, 1);
    repeat (8) cycle(1, 1, 0, '0, 0);
    check_eq("halt_deliveries", n_deliv, 4);
    check_eq("halt_still_halted", s_halted, 1);
    halt_addr = -1;
    cycle(1, 1, 1, 8'h00, 0);
    cycle(1, 1, 0, '0, 0);
    check_eq("halt_cleared", s_halted, 0);
    n_deliv = 0;
    repeat (6) cycle(1, 1, 0, '0, 0);
    check_eq("halt_resume", (n_deliv >= 2), 1);
`endif

    // Randomized traffic.
    lat_min = 1; lat_max = 4;
    halt_addr = -1;
    repeat (2) cycle(1, 1, 0, '0, 1);
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      logic ir, mr, rv, rs;
      logic [AW-1:0] rpc;
      rs  = ($urandom_range(399, 0) == 0);
      rv  = ($urandom_range(39, 0) == 0);
      rpc = AW'($urandom);
      ir  = ($urandom_range(3, 0) != 0);
      mr  = ($urandom_range(2, 0) != 0);
      cycle(ir, mr, rv, rpc, rs);
    end
    check_eq("random_liveness", (n_deliv > 300), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
